n64_request_scheduler: RTL and testbench

Serialises service requests raised by the N64-facing save/peripheral emulation blocks (flashram commit/erase, RTC read/write, config command) toward the single controller-side service port, one request at a time. It performs round-robin selection among pending requesters, runs an offer/accept/complete handshake with the controller, and returns a one-cycle done pulse to the requester it served. A watchdog guarantees that no requester is left pending forever, and an N64 reset flushes any request in flight.

---
 rtl/n64_request_scheduler_pkg.sv | 17 +
 rtl/n64_rr_pick.sv | 30 +++
 rtl/n64_request_scheduler.sv | 122 ++++++++++++
 tb/tb_n64_request_scheduler.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/n64_request_scheduler_pkg.sv
// n64_request_scheduler_pkg: shared types and constants for the
// request scheduler (FSM states, requester indices, default count).
package n64_request_scheduler_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_OFFER,
        S_SERVICE,
        S_COMPLETE
    } e_sched_state;

    localparam int REQ_FLASHRAM    = 0;
    localparam int REQ_RTC         = 1;
    localparam int REQ_CFG         = 2;
    localparam int NUM_REQ_DEFAULT = 3;

endpackage

// File: rtl/n64_rr_pick.sv
// n64_rr_pick: combinational round-robin priority encoder.
// Ports: mask (eligible vector), start (search origin), hit, idx.
module n64_rr_pick #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] start,
    output logic          hit,
    output logic [IW-1:0] idx
);

    int j;

    // First set bit at or after start, wrapping modulo N.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        j   = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(start) + i;
            if (j >= N) j = j - N;
            if (!hit && mask[j]) begin
                hit = 1'b1;
                idx = IW'(j);
            end
        end
    end

endmodule

// File: rtl/n64_request_scheduler.sv
// n64_request_scheduler: serialises requester service toward one controller port.
// Ports: req_pending/req_done/req_error (requesters), ctl_* (controller), busy, timeout_count.
module n64_request_scheduler
    import n64_request_scheduler_pkg::*;
#(
    parameter int NUM_REQ        = NUM_REQ_DEFAULT,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int IW             = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               n64_reset,
    input  logic [NUM_REQ-1:0] req_pending,
    output logic [NUM_REQ-1:0] req_done,
    output logic [NUM_REQ-1:0] req_error,
    output logic               ctl_valid,
    output logic [IW-1:0]      ctl_id,
    input  logic               ctl_ack,
    input  logic               ctl_done,
    input  logic               ctl_error,
    output logic               ctl_abort,
    output logic               busy,
    output logic [7:0]         timeout_count
);

    localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES - 1);

    e_sched_state       state;
    logic [IW-1:0]      rr_ptr;
    logic [NUM_REQ-1:0] hold_mask;
    logic [WD_W-1:0]    wd;

    logic               pick_hit;
    logic [IW-1:0]      pick_idx;
    logic [NUM_REQ-1:0] id_onehot;
    logic [IW-1:0]      id_next;
    logic               finish_ok;

    assign id_onehot = NUM_REQ'(1) << ctl_id;
    assign id_next   = (ctl_id == IW'(NUM_REQ - 1)) ? '0 : ctl_id + IW'(1);

    // ack+done may land together in OFFER; SERVICE needs only done.
    assign finish_ok = ctl_done && (ctl_ack || state == S_SERVICE);

    n64_rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .mask  (req_pending & ~hold_mask),
        .start (rr_ptr),
        .hit   (pick_hit),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            rr_ptr        <= '0;
            hold_mask     <= '0;
            wd            <= '0;
            ctl_id        <= '0;
            ctl_valid     <= 1'b0;
            ctl_abort     <= 1'b0;
            req_done      <= '0;
            req_error     <= '0;
            busy          <= 1'b0;
            timeout_count <= '0;
        end else begin
            ctl_abort <= 1'b0;
            req_done  <= '0;
            req_error <= '0;
            unique case (state)
                S_IDLE: begin
                    // Mask only shields the requester for one IDLE cycle.
                    hold_mask <= '0;
                    if (!n64_reset && pick_hit) begin
                        ctl_id    <= pick_idx;
                        wd        <= '0;
                        ctl_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= S_OFFER;
                    end
                end
                S_OFFER, S_SERVICE: begin
                    if (n64_reset) begin
                        ctl_abort <= 1'b1;
                        ctl_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end else if (finish_ok) begin
                        ctl_valid <= 1'b0;
                        req_done  <= id_onehot;
                        req_error <= ctl_error ? id_onehot : '0;
                        state     <= S_COMPLETE;
                    end else if (wd == WD_MAX) begin
                        ctl_valid <= 1'b0;
                        req_done  <= id_onehot;
                        req_error <= id_onehot;
                        state     <= S_COMPLETE;
                        if (timeout_count != 8'hff)
                            timeout_count <= timeout_count + 8'd1;
                    end else begin
                        wd <= wd + WD_W'(1);
                        if (state == S_OFFER && ctl_ack) begin
                            ctl_valid <= 1'b0;
                            state     <= S_SERVICE;
                        end
                    end
                end
                S_COMPLETE: begin
                    rr_ptr    <= id_next;
                    hold_mask <= id_onehot;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_n64_request_scheduler.sv
// tb_n64_request_scheduler: directed stimulus with a completion scoreboard.
// Expected completions are queued at issue; a negedge monitor checks them.
module tb_n64_request_scheduler;
    import n64_request_scheduler_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       n64_reset = 1'b0;
    logic [2:0] req_pending = '0;
    logic [2:0] req_done;
    logic [2:0] req_error;
    logic       ctl_valid;
    logic [1:0] ctl_id;
    logic       ctl_ack = 1'b0;
    logic       ctl_done = 1'b0;
    logic       ctl_error = 1'b0;
    logic       ctl_abort;
    logic       busy;
    logic [7:0] timeout_count;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        int id;
        bit err;
    } exp_t;

    exp_t exp_q[$];

    n64_request_scheduler #(
        .NUM_REQ        (3),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .n64_reset     (n64_reset),
        .req_pending   (req_pending),
        .req_done      (req_done),
        .req_error     (req_error),
        .ctl_valid     (ctl_valid),
        .ctl_id        (ctl_id),
        .ctl_ack       (ctl_ack),
        .ctl_done      (ctl_done),
        .ctl_error     (ctl_error),
        .ctl_abort     (ctl_abort),
        .busy          (busy),
        .timeout_count (timeout_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int id, input bit err);
        exp_t e;
        e.id  = id;
        e.err = err;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: every done pulse must match the queue head.
    always @(negedge clk) begin
        if (reset_n && req_done != 3'b000) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL done_unexpected: got %b expected none",
                         req_done);
            end else begin
                exp_t e;
                logic [2:0] oh;
                e  = exp_q.pop_front();
                oh = 3'b001 << e.id;
                chk("sb_done", 32'(req_done), 32'(oh));
                chk("sb_error", 32'(req_error), e.err ? 32'(oh) : 32'd0);
            end
        end
    end

    task automatic wait_valid(input string name, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        while (n < 60) begin
            @(negedge clk);
            if (ctl_valid) begin
                ok = 1'b1;
                break;
            end
            n++;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL %s: ctl_valid got 0 expected 1", name);
        end
    endtask

    task automatic wait_dones(input string name, input int cnt,
                              input int lim);
        int seen;
        int n;
        seen = 0;
        n    = 0;
        while (seen < cnt && n < lim) begin
            @(negedge clk);
            if (req_done != 3'b000) seen++;
            n++;
        end
        chk(name, 32'(seen), 32'(cnt));
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        req_pending = '0;
        ctl_ack     = 1'b0;
        ctl_done    = 1'b0;
        ctl_error   = 1'b0;
        n64_reset   = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        bit ok;
        int n;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(ctl_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(req_done), 0);
        chk("rst_id", 32'(ctl_id), 0);
        chk("rst_tocnt", 32'(timeout_count), 0);
        chk("rst_abort", 32'(ctl_abort), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Single request from RTC with delayed ack and done
        req_pending = 3'b010;
        push(REQ_RTC, 1'b0);
        wait_valid("single_valid", ok);
        chk("single_id", 32'(ctl_id), REQ_RTC);
        repeat (2) @(negedge clk);
        ctl_ack = 1'b1;
        @(negedge clk);
        ctl_ack = 1'b0;
        chk("single_svc_valid", 32'(ctl_valid), 0);
        chk("single_svc_busy", 32'(busy), 1);
        repeat (4) @(negedge clk);
        ctl_done = 1'b1;
        @(negedge clk);
        ctl_done = 1'b0;
        chk("single_done", 32'(req_done), 32'b010);
        chk("single_busy_c", 32'(busy), 1);
        req_pending = 3'b000;
        @(negedge clk);
        chk("single_done_1cyc", 32'(req_done), 0);
        chk("single_busy_low", 32'(busy), 0);

        // Round-robin with all three requesters pending
        do_reset();
        for (int i = 0; i < 6; i++) push(i % 3, 1'b0);
        req_pending = 3'b111;
        ctl_ack     = 1'b1;
        ctl_done    = 1'b1;
        wait_dones("rr_count", 6, 60);
        req_pending = 3'b000;
        ctl_ack     = 1'b0;
        ctl_done    = 1'b0;
        @(negedge clk);
        chk("rr_idle", 32'(ctl_valid), 0);

        // Same requester back-to-back: hold_mask delays regrant
        push(REQ_FLASHRAM, 1'b0);
        push(REQ_FLASHRAM, 1'b0);
        req_pending = 3'b001;
        ctl_ack     = 1'b1;
        ctl_done    = 1'b1;
        wait_dones("b2b_first", 1, 20);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_done == 3'b000 && n < 20);
        chk("b2b_gap", 32'(n), 4);
        req_pending = 3'b000;
        ctl_ack     = 1'b0;
        ctl_done    = 1'b0;
        @(negedge clk);

        // Error passthrough: ack+done+error in the offer cycle
        push(REQ_CFG, 1'b1);
        req_pending = 3'b100;
        ctl_ack     = 1'b1;
        ctl_done    = 1'b1;
        ctl_error   = 1'b1;
        wait_valid("err_valid", ok);
        @(negedge clk);
        chk("err_direct_done", 32'(req_done), 32'b100);
        chk("err_flag", 32'(req_error), 32'b100);
        req_pending = 3'b000;
        ctl_ack     = 1'b0;
        ctl_done    = 1'b0;
        ctl_error   = 1'b0;
        @(negedge clk);

        // Watchdog: controller never acks
        push(REQ_CFG, 1'b1);
        req_pending = 3'b100;
        wait_valid("to_valid", ok);
        n = 1;
        while (n < 40) begin
            @(negedge clk);
            if (!ctl_valid) break;
            n++;
        end
        chk("to_offer_len", 32'(n), 16);
        chk("to_done", 32'(req_done), 32'b100);
        chk("to_count1", 32'(timeout_count), 1);
        req_pending = 3'b000;
        @(negedge clk);

        // done on the final watchdog cycle wins over the timeout
        push(REQ_RTC, 1'b0);
        req_pending = 3'b010;
        wait_valid("edge_valid", ok);
        ctl_ack = 1'b1;
        @(negedge clk);
        ctl_ack = 1'b0;
        repeat (14) @(negedge clk);
        ctl_done = 1'b1;
        @(negedge clk);
        ctl_done = 1'b0;
        chk("edge_done", 32'(req_done), 32'b010);
        chk("edge_noerr", 32'(req_error), 0);
        chk("edge_count", 32'(timeout_count), 1);
        req_pending = 3'b000;
        @(negedge clk);

        // Saturation of timeout_count
        for (int i = 0; i < 259; i++) push(REQ_CFG, 1'b1);
        req_pending = 3'b100;
        wait_dones("to_repeat", 259, 259 * 30);
        req_pending = 3'b000;
        chk("to_saturate", 32'(timeout_count), 255);
        repeat (2) @(negedge clk);

        // n64_reset during SERVICE aborts without completion
        req_pending = 3'b001;
        wait_valid("abort_valid", ok);
        chk("abort_id", 32'(ctl_id), REQ_FLASHRAM);
        ctl_ack = 1'b1;
        @(negedge clk);
        ctl_ack = 1'b0;
        @(negedge clk);
        n64_reset   = 1'b1;
        req_pending = 3'b111;
        @(negedge clk);
        chk("abort_pulse", 32'(ctl_abort), 1);
        chk("abort_valid0", 32'(ctl_valid), 0);
        chk("abort_busy0", 32'(busy), 0);
        @(negedge clk);
        chk("abort_1cyc", 32'(ctl_abort), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_nogrant", 32'(ctl_valid), 0);
        end
        n64_reset = 1'b0;
        push(REQ_FLASHRAM, 1'b0);
        wait_valid("abort_regrant", ok);
        chk("abort_rr_kept", 32'(ctl_id), REQ_FLASHRAM);
        ctl_ack  = 1'b1;
        ctl_done = 1'b1;
        @(negedge clk);
        ctl_ack     = 1'b0;
        ctl_done    = 1'b0;
        req_pending = 3'b000;
        @(negedge clk);

        // Asynchronous reset_n during OFFER
        req_pending = 3'b010;
        wait_valid("async_valid", ok);
        chk("async_pre_id", 32'(ctl_id), REQ_RTC);
        #2 reset_n = 1'b0;
        #1;
        chk("async_valid0", 32'(ctl_valid), 0);
        chk("async_busy0", 32'(busy), 0);
        chk("async_id0", 32'(ctl_id), 0);
        @(negedge clk);
        req_pending = 3'b111;
        reset_n     = 1'b1;
        push(REQ_FLASHRAM, 1'b0);
        wait_valid("async_regrant", ok);
        chk("async_rr0", 32'(ctl_id), REQ_FLASHRAM);
        ctl_ack  = 1'b1;
        ctl_done = 1'b1;
        @(negedge clk);
        ctl_ack     = 1'b0;
        ctl_done    = 1'b0;
        req_pending = 3'b000;
        repeat (3) @(negedge clk);

        chk("sb_drained", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
